// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and multi-cycle load wait.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module pipeline_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              ResultSrcE,
  input  logic              ResultSrcM,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_cycles
);

  localparam int WCNT_W = $clog2(MEM_LAT) + 1;
  localparam bit MULTI  = (MEM_LAT > 1);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state;
  logic [WCNT_W-1:0]  wcnt;
  logic               load_m;
  logic               last_wait;
  logic               mem_stall;
  logic               load_use;
  logic [1:0]         fwd_a;
  logic [1:0]         fwd_b;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != '0) && (rd_m == rs))      sel = 2'b10;
    else if (wr_w && (rd_w != '0) && (rd_w == rs)) sel = 2'b01;
    return sel;
  endfunction

  assign fwd_a = fwd_sel(Rs1_E, RegWriteM, RdM, RegWriteW, RdW);
  assign fwd_b = fwd_sel(Rs2_E, RegWriteM, RdM, RegWriteW, RdW);

  assign load_use = ResultSrcE & RegWriteE & (RdE != '0) & ((RdE == Rs1_D) | (RdE == Rs2_D));

  // The load stays held in M for the whole wait, so the release cycle must not re-arm.
  assign load_m    = ResultSrcM & RegWriteM & MULTI;
  assign last_wait = (wcnt == WCNT_W'(MEM_LAT - 1));
  assign mem_stall = (state == IDLE) ? load_m : !last_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: if (load_m) begin
          state <= WAIT;
          wcnt  <= WCNT_W'(1);
        end
        WAIT: if (last_wait) begin
          state <= IDLE;
          wcnt  <= '0;
        end else begin
          wcnt  <= wcnt + WCNT_W'(1);
        end
        default: begin
          state <= IDLE;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // Priority: memory wait, then taken branch, then load-use; all forced low in reset.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    mem_busy  = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      if (mem_stall) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        StallE   = 1'b1;
        StallM   = 1'b1;
        FlushW   = 1'b1;
        mem_busy = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (StallF && (stall_q != '1))            stall_q <= stall_q + CNT_W'(1);
      if ((FlushD || FlushE) && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: directed hazard scenarios plus random traffic
// compared against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_busy;
  logic [CNT_W-1:0]  stall_cycles, flush_cycles;

  int n_vec = 0;
  int n_err = 0;

  // Expected mem_stall for the cycles following a load start (1 = stall, trailing 0 = release).
  logic [0:0] exp_q[$];
  int         m_stall_cnt;
  int         m_flush_cnt;

  pipeline_hazard_unit #(.REG_AW(REG_AW), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM), .PCSrcE(PCSrcE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_busy(mem_busy),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [REG_AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int exp_cnt(input int m);
`ifdef HAZARD_PERF_CNT_EN
    return m;
`else
    return 0 + (m * 0);
`endif
  endfunction

  task automatic set_idle();
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, ResultSrcE, ResultSrcM, PCSrcE} = '0;
  endtask

  task automatic set_random();
    Rs1_D = REG_AW'($urandom_range(0, 3));
    Rs2_D = REG_AW'($urandom_range(0, 3));
    Rs1_E = REG_AW'($urandom_range(0, 3));
    Rs2_E = REG_AW'($urandom_range(0, 3));
    RdE   = REG_AW'($urandom_range(0, 3));
    RdM   = REG_AW'($urandom_range(0, 3));
    RdW   = REG_AW'($urandom_range(0, 3));
    RegWriteE  = 1'($urandom_range(0, 1));
    RegWriteM  = 1'($urandom_range(0, 1));
    RegWriteW  = 1'($urandom_range(0, 1));
    ResultSrcE = 1'($urandom_range(0, 1));
    ResultSrcM = ($urandom_range(0, 3) == 0);
    PCSrcE     = ($urandom_range(0, 4) == 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  // One clock: check outputs on the falling edge, advance the model on the rising edge.
  task automatic run_cycle();
    logic ms, lu, e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
    @(negedge clk);
    if (exp_q.size() > 0) ms = exp_q[0];
    else                  ms = ResultSrcM && RegWriteM && (MEM_LAT > 1);
    lu = ResultSrcE && RegWriteE && RdE != 0 && (RdE == Rs1_D || RdE == Rs2_D);
    {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw} = '0;
    if (ms)          {e_sf, e_sd, e_se, e_sm, e_fw} = 5'b11111;
    else if (PCSrcE) {e_fd, e_fe} = 2'b11;
    else if (lu)     {e_sf, e_sd, e_fe} = 3'b111;
    check("ForwardAE", 32'(ForwardAE), 32'(exp_fwd(Rs1_E)));
    check("ForwardBE", 32'(ForwardBE), 32'(exp_fwd(Rs2_E)));
    check("stalls", 32'({StallF, StallD, StallE, StallM}), 32'({e_sf, e_sd, e_se, e_sm}));
    check("flushes", 32'({FlushD, FlushE, FlushW}), 32'({e_fd, e_fe, e_fw}));
    check("mem_busy", 32'(mem_busy), 32'(ms));
    check("stall_cycles", 32'(stall_cycles), 32'(exp_cnt(m_stall_cnt)));
    check("flush_cycles", 32'(flush_cycles), 32'(exp_cnt(m_flush_cnt)));
    @(posedge clk);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    else if (ms) begin
      for (int i = 0; i < MEM_LAT - 2; i++) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    if (e_sf && m_stall_cnt < CNT_MAX) m_stall_cnt++;
    if ((e_fd || e_fe) && m_flush_cnt < CNT_MAX) m_flush_cnt++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'({StallF, StallD, StallE, StallM}), 32'd0);
    check({tag, "_flush"}, 32'({FlushD, FlushE, FlushW}), 32'd0);
    check({tag, "_fwd"}, 32'({ForwardAE, ForwardBE}), 32'd0);
    check({tag, "_busy"}, 32'(mem_busy), 32'd0);
    check({tag, "_cnt"}, 32'({stall_cycles, flush_cycles}), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_idle();
    model_reset();
    // Reset with every hazard condition active: outputs must still be quiet.
    rst = 1'b0;
    RdM = 5; RegWriteM = 1; ResultSrcM = 1; Rs1_E = 5; PCSrcE = 1;
    ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2_D = 7;
    #12;
    check_all_zero("reset_forced");
    set_idle();
    apply_reset();

    // Forwarding: M beats W, and RdM=0 falls through to W.
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1_E = 5;
    #1 check("fwd_m_prio", 32'(ForwardAE), 32'd2);
    RdM = 0;
    #1 check("fwd_w_rdm0", 32'(ForwardAE), 32'd1);
    run_cycle();
    set_idle();

    // Load-use on Rs2_D, then with RdE=0 no stall.
    ResultSrcE = 1; RegWriteE = 1; RdE = 7; Rs2_D = 7;
    #1 check("loaduse", 32'({StallF, StallD, FlushE}), 32'h7);
    run_cycle();
    set_idle();
    run_cycle();
    ResultSrcE = 1; RegWriteE = 1; RdE = 0; Rs2_D = 0;
    #1 check("loaduse_rd0", 32'({StallF, StallD, FlushE}), 32'h0);
    run_cycle();
    set_idle();

    // Load wait: exactly MEM_LAT-1 stall cycles counted from a fresh reset.
    apply_reset();
    ResultSrcM = 1; RegWriteM = 1; RdM = 3;
    for (int i = 0; i < MEM_LAT; i++) run_cycle();
    set_idle();
    #1 check("load_release", 32'({StallF, StallM, FlushW, mem_busy}), 32'd0);
    check("load_stall_cnt", 32'(stall_cycles), 32'(exp_cnt(MEM_LAT - 1)));
    run_cycle();

    // Branch during the wait is held off until release.
    ResultSrcM = 1; RegWriteM = 1; RdM = 3;
    run_cycle();
    PCSrcE = 1;
    #1 check("br_in_wait", 32'({FlushD, FlushE}), 32'd0);
    run_cycle();
    #1 check("br_release", 32'({FlushD, FlushE}), 32'h3);
    run_cycle();
    set_idle();
    run_cycle();

    // Reset in the middle of a wait aborts it.
    ResultSrcM = 1; RegWriteM = 1; RdM = 2;
    run_cycle();
    rst = 1'b0;
    model_reset();
    #1 check_all_zero("mid_wait_rst");
    set_idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) run_cycle();

    // Back-to-back loads: a load still present after release starts a new wait.
    ResultSrcM = 1; RegWriteM = 1; RdM = 4;
    for (int i = 0; i < 2 * MEM_LAT + 1; i++) run_cycle();
    set_idle();
    run_cycle();

    // Random traffic against the model (also exercises counter saturation).
    for (int i = 0; i < 600; i++) begin
      set_random();
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
